// File: rtl/trace_stream_arbiter_if.sv
// Trace stream bundle: NUM_SOURCES source-side AXI4-Stream lanes plus one merged output lane.
// The slave modport is the arbiter's view; the master modport is the sources/sink environment.
interface trace_stream_if #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 32
);
    localparam int ID_WIDTH = $clog2(NUM_SOURCES);

    logic [NUM_SOURCES-1:0]            s_tvalid;
    logic [NUM_SOURCES-1:0]            s_tready;
    logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_SOURCES-1:0]            s_tlast;
    logic                              m_tvalid;
    logic                              m_tready;
    logic [DATA_WIDTH-1:0]             m_tdata;
    logic                              m_tlast;
    logic [ID_WIDTH-1:0]               m_tid;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tid
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tid
    );
endinterface

// File: rtl/trace_stream_arbiter.sv
// Round-robin arbiter with packet lock merging per-core trace streams into one registered
// AXI4-Stream output; each beat carries its source index on m_tid.
//
// state     | meaning
// ST_IDLE   | no grant held; arbitrate among enabled valid sources (s_tready all 0)
// ST_LOCKED | grant_id owns the output until tlast, burst limit or idle timeout
module trace_stream_arbiter #(
    parameter int NUM_SOURCES  = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64,
    localparam int ID_WIDTH    = $clog2(NUM_SOURCES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SOURCES-1:0] src_enable,
    trace_stream_if.slave          bus,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic                   locked
);
    localparam int CNT_MAX = (MAX_BURST > IDLE_TIMEOUT) ? MAX_BURST : IDLE_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BURST_TC = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] IDLE_TC  = CNT_W'(IDLE_TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t                   state_q, state_d;
    logic [ID_WIDTH-1:0]      grant_q, grant_d;
    logic [CNT_W-1:0]         burst_q, burst_d;
    logic [CNT_W-1:0]         idle_q, idle_d;
    logic                     m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0]    m_tdata_q, m_tdata_d;
    logic                     m_tlast_q, m_tlast_d;
    logic [ID_WIDTH-1:0]      m_tid_q, m_tid_d;

    logic [NUM_SOURCES-1:0]   req;
    logic [ID_WIDTH-1:0]      pick;
    logic                     found;
    logic [NUM_SOURCES-1:0]   s_tready_c;
    logic                     g_valid, g_last, out_free, accept, release_c;
    logic [DATA_WIDTH-1:0]    g_data;

    assign req = bus.s_tvalid & src_enable;

    // Search starts just after the last grant so every requester is served in turn.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = grant_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            idx = (int'(grant_q) + k) % NUM_SOURCES;
            if (!found && req[idx]) begin
                pick  = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        burst_d    = burst_q;
        idle_d     = idle_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;
        s_tready_c = '0;
        accept     = 1'b0;
        release_c  = 1'b0;
        g_valid    = bus.s_tvalid[grant_q];
        g_last     = bus.s_tlast[grant_q];
        g_data     = bus.s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        out_free   = !m_tvalid_q || bus.m_tready;

        if (m_tvalid_q && bus.m_tready) m_tvalid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                s_tready_c[grant_q] = out_free;
                accept = g_valid && out_free;
                if (accept) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = g_data;
                    m_tlast_d  = g_last;
                    m_tid_d    = grant_q;
                    idle_d     = '0;
                    if (burst_q != '1) burst_d = burst_q + 1'b1;
                end else if (!g_valid && idle_q != '1) begin
                    idle_d = idle_q + 1'b1;
                end
                // A stalled-but-valid source is not idle: only missing tvalid counts.
                release_c = (accept && g_last)
                         || (accept && (MAX_BURST != 0) && (burst_q == BURST_TC))
                         || ((IDLE_TIMEOUT != 0) && !g_valid && (idle_q == IDLE_TC));
                if (release_c) begin
                    state_d = ST_IDLE;
                    burst_d = '0;
                    idle_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= ID_WIDTH'(NUM_SOURCES - 1);
            burst_q    <= '0;
            idle_q     <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            burst_q    <= burst_d;
            idle_q     <= idle_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            m_tid_q    <= m_tid_d;
        end
    end

    assign bus.s_tready = s_tready_c;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tlast  = m_tlast_q;
    assign bus.m_tid    = m_tid_q;
    assign grant_id     = grant_q;
    assign locked       = (state_q == ST_LOCKED);
endmodule
